// File: rtl/axis_pkt_fifo.sv
// rtl/axis_pkt_fifo.sv - parametrised AXI4-Stream FIFO with occupancy/frame-count status
// Optional store-and-forward packet mode: define AXIS_PKT_FIFO_STORE_FWD_EN.
module axis_pkt_fifo #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 1,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [AW:0]       occupancy,
  output logic [AW:0]       frame_count
);

  localparam int BW = DATA_W + KEEP_W + USER_W + 1;

  logic [BW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [AW:0]   frm_q, frm_d;
  logic          ready_q;
  logic          full, empty;
  logic          wr_en, rd_en;
  logic          wr_last, rd_last;
  logic [BW-1:0] rd_beat;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Full blocks writes even when a read retires in the same cycle.
  assign s_axis_tready = ready_q && !full;
  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign rd_en         = m_axis_tvalid && m_axis_tready;
  assign wr_last       = wr_en && s_axis_tlast;
  assign rd_last       = rd_en && m_axis_tlast;

  assign rd_beat = mem_q[rd_ptr_q[AW-1:0]];
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = rd_beat;

  assign occupancy   = occ_q;
  assign frame_count = frm_q;

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
  logic release_q, release_d;

  // An oversize frame can never complete while full, so forward it cut-through.
  always_comb begin
    release_d = release_q;
    if (rd_last) begin
      release_d = 1'b0;
    end else if (full && (frm_q == '0)) begin
      release_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      release_q <= 1'b0;
    end else begin
      release_q <= release_d;
    end
  end

  assign m_axis_tvalid = !empty && ((frm_q != '0) || release_q);
`else
  assign m_axis_tvalid = !empty;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    frm_d    = frm_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    case ({wr_last, rd_last})
      2'b10:   frm_d = frm_q + (AW+1)'(1);
      2'b01:   frm_d = frm_q - (AW+1)'(1);
      default: frm_d = frm_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      frm_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      frm_q    <= frm_d;
      ready_q  <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb/tb_axis_pkt_fifo.sv - scoreboard bench for axis_pkt_fifo
module tb_axis_pkt_fifo;
  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int USER_W = 1;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int BW     = DATA_W + KEEP_W + USER_W + 1;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [DATA_W-1:0] s_axis_tdata;
  logic [KEEP_W-1:0] s_axis_tkeep;
  logic [USER_W-1:0] s_axis_tuser;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic [USER_W-1:0] m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [AW:0]       occupancy;
  logic [AW:0]       frame_count;

  axis_pkt_fifo #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .occupancy(occupancy), .frame_count(frame_count)
  );

  always #5 aclk = ~aclk;

  int            checks = 0;
  int            errors = 0;
  logic [BW-1:0] sb[$];
  logic          ready_m = 1'b0;
  logic          release_m = 1'b0;
  int            in_cnt, out_cnt;
  logic          last_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sb_frames();
    int n = 0;
    foreach (sb[i]) if (sb[i][0]) n++;
    return n;
  endfunction

  function automatic logic exp_mvalid();
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    return (sb.size() != 0) && ((sb_frames() != 0) || release_m);
`else
    return sb.size() != 0;
`endif
  endfunction

  task automatic reset_model();
    sb.delete();
    ready_m   = 1'b0;
    release_m = 1'b0;
  endtask

  // Compare at the falling edge, then advance the model over the next rising edge.
  task automatic step();
    logic exp_sready, exp_mv, wr, rd, pop_last;
    @(negedge aclk);
    exp_sready = ready_m && (sb.size() < DEPTH);
    exp_mv     = exp_mvalid();
    check("s_tready", s_axis_tready, exp_sready);
    check("m_tvalid", m_axis_tvalid, exp_mv);
    check("occupancy", occupancy, sb.size());
    check("frame_count", frame_count, sb_frames());
    if (exp_mv)
      check("m_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, sb[0]);
    wr = s_axis_tvalid && exp_sready;
    rd = exp_mv && m_axis_tready;
    @(posedge aclk);
    pop_last = 1'b0;
    if (!aresetn) begin
      reset_model();
    end else begin
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
      if (rd && sb[0][0]) release_m = 1'b0;
      else if ((sb.size() == DEPTH) && (sb_frames() == 0)) release_m = 1'b1;
`endif
      if (rd) begin
        pop_last = sb[0][0];
        void'(sb.pop_front());
        out_cnt++;
      end
      if (wr) begin
        sb.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast});
        in_cnt++;
      end
      ready_m = 1'b1;
    end
    last_wr = wr;
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic [3:0] k,
                        input logic u, input logic l);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
  endtask

  // Hold a beat until accepted, bounded by a cycle budget.
  task automatic drive_beat(input logic [31:0] d, input logic l);
    int n = 0;
    set_in(1'b1, d, 4'hF, d[0], l);
    last_wr = 1'b0;
    while (!last_wr && n < 64) begin
      step();
      n++;
    end
    if (!last_wr) check("drive_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic async_reset();
    aresetn = 1'b0;
    reset_model();
    #1;
    check("rst_occ", occupancy, 0);
    check("rst_frm", frame_count, 0);
    check("rst_mvalid", m_axis_tvalid, 0);
    check("rst_sready", s_axis_tready, 0);
    repeat (3) step();
    aresetn = 1'b1;
    step();
  endtask

  initial begin
    aresetn = 1'b0;
    m_axis_tready = 1'b0;
    set_in(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    in_cnt = 0; out_cnt = 0; last_wr = 1'b0;

    // Reset hold and release
    repeat (10) step();
    aresetn = 1'b1;
    step();
    check("rst_release_sready", s_axis_tready, 1);
    check("rst_release_occ", occupancy, 0);

    // Streaming one 8-beat frame
    m_axis_tready = 1'b1;
    out_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 32'(i), 4'hF, 1'b0, i == 8);
      step();
`ifndef AXIS_PKT_FIFO_STORE_FWD_EN
      if (i == 1) check("stream_latency", m_axis_tvalid, 1);
`endif
    end
    s_axis_tvalid = 1'b0;
    repeat (4) step();
    check("stream_out_cnt", out_cnt, 8);

    // Fill to full, push at full, then drain
    m_axis_tready = 1'b0;
    in_cnt = 0; out_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 32'h100 + 32'(i), 4'hF, 1'b1, 1'b0);
      step();
    end
    check("fill_accepted", in_cnt, 16);
    check("fill_occ", occupancy, 16);
    check("fill_sready", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    set_in(1'b1, 32'hDEAD, 4'hF, 1'b0, 1'b0);
    step();
    check("full_push_acc", in_cnt, 16);
    check("full_push_occ", occupancy, 15);
    s_axis_tvalid = 1'b0;
    repeat (20) step();
    check("drain_out_cnt", out_cnt, 16);
    check("drain_occ", occupancy, 0);

    // Random concurrent traffic around occupancy 5
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'h200 + 32'(i), 4'hF, 1'b0, (i == 2) || (i == 4));
      step();
    end
    check("rand_start_occ", occupancy, 5);
    for (int i = 0; i < 100; i++) begin
      set_in($urandom_range(0, 1) == 1, $urandom, 4'($urandom), 1'($urandom),
             $urandom_range(0, 3) == 0);
      m_axis_tready = $urandom_range(0, 1) == 1;
      step();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (20) step();

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    // Store-and-forward gating and oversize release
    async_reset();
    out_cnt = 0;
    for (int i = 1; i <= 7; i++) drive_beat(32'h300 + 32'(i), 1'b0);
    step();
    check("sf_gated", m_axis_tvalid, 0);
    drive_beat(32'h308, 1'b1);
    check("sf_release", m_axis_tvalid, 1);
    repeat (10) step();
    check("sf_out_cnt", out_cnt, 8);
    out_cnt = 0;
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 20; i++) drive_beat(32'h400 + 32'(i), i == 20);
    repeat (24) step();
    check("sf_big_out_cnt", out_cnt, 20);
    check("sf_big_occ", occupancy, 0);
`endif

    // Reset mid-frame
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 3; i++) drive_beat(32'h500 + 32'(i), 1'b0);
    check("mid_occ_before", occupancy, 3);
    async_reset();
    check("mid_occ_after", occupancy, 0);
    check("mid_mvalid_after", m_axis_tvalid, 0);
    m_axis_tready = 1'b1;
    out_cnt = 0;
    for (int i = 1; i <= 8; i++) drive_beat(32'h600 + 32'(i), i == 8);
    repeat (6) step();
    check("mid_next_frame_cnt", out_cnt, 8);
    check("mid_final_occ", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Parametrised AXI4-Stream FIFO carrying tdata/tkeep/tuser/tlast, replacing the fixed-width example FIFO in the stream example top. It sits between a frame source and a frame sink on a single clock domain. It adds depth/width generics, occupancy and frame-count status, and an optional store-and-forward packet mode selected at compile time.

## Interface
Parameters:
- DATA_W, 32, tdata width in bits, multiple of 8
- KEEP_W, DATA_W/8, tkeep width
- USER_W, 1, tuser width, ≥1
- DEPTH, 16, entries; power of two, ≥4
- AW, $clog2(DEPTH), derived; not to be overridden

Ports:
- aclk  in  1  clock, all logic rising-edge
- aresetn  in  1  reset; asynchronous assert, active-low
- s_axis_tdata  in  DATA_W  input beat data
- s_axis_tkeep  in  KEEP_W  input byte enables
- s_axis_tuser  in  USER_W  input sideband
- s_axis_tlast  in  1  input end-of-frame
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  FIFO can accept a beat
- m_axis_tdata  out  DATA_W  output beat data
- m_axis_tkeep  out  KEEP_W  output byte enables
- m_axis_tuser  out  USER_W  output sideband
- m_axis_tlast  out  1  output end-of-frame
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  sink accepts beat
- occupancy  out  AW+1  stored beats, 0..DEPTH
- frame_count  out  AW+1  complete frames stored (tlast written, not yet read)

## Operation
- Storage: DEPTH-entry array of {tdata,tkeep,tuser,tlast}, not reset. Write/read pointers AW+1 bits; full when MSBs differ and low bits equal, empty when equal.
- Write: beat stored at rising edge when s_axis_tvalid && s_axis_tready. s_axis_tready = ready_r && !full.
- Read: first-word-fall-through; m_axis_* show the entry at the read pointer; beat retired on m_axis_tvalid && m_axis_tready.
- Non-packet mode: m_axis_tvalid = !empty.
- occupancy: +1 write only, −1 read only, unchanged on both or neither.
- frame_count: +1 on accepted write with tlast, −1 on retired read with tlast; both in same cycle → unchanged.
- Full: no write even when a read occurs the same cycle (no pass-through at full). Empty: no bypass; data appears the cycle after it is written.
- Pointer wrap at DEPTH is silent; occupancy/frame_count never exceed DEPTH.
- tdata/tkeep/tuser are passed unmodified; no AXIS protocol checking.

## Timing
- Reset (aresetn low, asynchronous): pointers, occupancy, frame_count = 0; ready_r = 0 → s_axis_tready = 0; m_axis_tvalid = 0; m_axis_tdata/tkeep/tuser/tlast undefined (array content), only valid when tvalid = 1.
- ready_r set at first rising edge with aresetn high; s_axis_tready high from the following cycle.
- Reset mid-frame: all stored beats and partial frames discarded; no tlast fixup.
- Latency (non-packet): beat accepted at edge N → m_axis_tvalid high in cycle N+1 (1 cycle).
- Throughput: one beat/cycle in and out sustained at any occupancy between 1 and DEPTH−1.
- s_axis_tready low in the cycle after the edge that makes occupancy = DEPTH; high again the cycle after the first read from full.
- m_axis_tvalid, once high, stays high until the beat is retired (AXIS rule); it may drop only after a retire.

## Configuration
- Macro AXIS_PKT_FIFO_STORE_FWD_EN.
- Defined: store-and-forward. m_axis_tvalid = !empty && (frame_count != 0 || release_r). Accepted tlast at edge N → first beat of that frame valid in cycle N+1. Oversize guard: when full && frame_count == 0, release_r sets at the next edge and forwards the partial frame cut-through; release_r clears on the edge retiring a tlast beat. Reset value of release_r = 0.
- Undefined: cut-through only; frame gating and release_r logic absent; frame_count still provided.

## Test plan
- Reset: hold aresetn low 10 cycles, release → s_axis_tready = 0 for exactly 1 cycle after release then 1; m_axis_tvalid, occupancy, frame_count = 0 throughout.
- Streaming: 8-beat frame, data 0x1..0x8, tkeep 0xF, m_axis_tready = 1 → identical beats out, tlast only on 0x8; first output 1 cycle after first input (non-packet).
- Fill/drain, DEPTH = 16: m_axis_tready = 0, push 20 beats → 16 accepted, s_axis_tready low, occupancy = 16; drain → 16 beats in order, occupancy = 0; simultaneous push at full not accepted.
- Simultaneous read/write at occupancy 5 for 100 cycles with random tready/tvalid → occupancy and frame_count match scoreboard every cycle; no loss or reorder.
- Store-and-forward (macro defined): push 7 beats without tlast → m_axis_tvalid = 0; push tlast beat → tvalid high next cycle, 8 beats out; 20-beat frame into DEPTH = 16 → release at full, all 20 beats delivered in order.
- Reset mid-frame: assert aresetn low after 3 of 8 beats, release → occupancy = 0, no beats output, next full frame passes intact.
